i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- Serial audio transmitter: the consumer end of the sound generator's sample interface.
- Generates the sample_strobe that paces sample production, captures each left/right 16-bit pair, and serializes it onto a standard I2S link (bclk, lrclk, sdata) towards the external DAC.
- One stereo frame per strobe; all timing derived from clk by an integer divider.

Parameters:
- HALF_BCLK_DIV, 4: clk cycles per bclk half-period; legal range ≥1.
- SAMPLE_W, 16: bits per channel; frame = 2*SAMPLE_W bclk periods.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  run/idle control, synchronous
- left_sample  input  SAMPLE_W  left sample from generator, valid from 1 clk after sample_strobe
- right_sample  input  SAMPLE_W  right sample from generator, same timing
- sample_strobe  output  1  one-clk request pulse, once per frame
- bclk  output  1  bit clock
- lrclk  output  1  word select: 0 = left, 1 = right
- sdata  output  1  serial data, MSB first

Behaviour:
- Reset (async, rst=1) and idle state:
  - div_cnt = 0; bit_cnt = 2W-1 (W = SAMPLE_W).
  - bclk = 0, lrclk = 0, sdata = 0, sample_strobe = 0.
  - Shift register and both holding registers = 0.
- Divider, while enable=1:
  - div_cnt counts 0..HALF_BCLK_DIV-1 and wraps.
  - bclk toggles on the clk edge where div_cnt wraps.
  - bclk period = 2*HALF_BCLK_DIV clk cycles.
- Falling bclk event (the clk edge driving bclk 1→0), all in that same edge:
  - bit_cnt advances mod 2W.
  - sdata updates.
  - lrclk updates.
- Frame start (falling event where bit_cnt becomes 0):
  - Shift register loads {left_hold, right_hold}.
  - sample_strobe goes 1 for exactly one clk cycle.
- Sample capture:
  - On the clk edge one cycle after sample_strobe is high, left_hold/right_hold load left_sample/right_sample.
  - Samples captured for strobe N are transmitted in frame N+1, so latency = one frame.
- Bit mapping (sdata value during bit_cnt = n):
  - n in 0..W-1: left_hold[W-1-n].
  - n in W..2W-1: right_hold[2W-1-n].
- lrclk mapping (leads data by one bit, I2S standard):
  - lrclk = 1 for bit_cnt in W-1..2W-2.
  - lrclk = 0 otherwise.
- sdata/lrclk stability: both change only on falling bclk events, so they are stable across every rising bclk edge (the DAC samples on rising).
- Default frame length: 2*16*2*4 = 256 clks.
- Strobe spacing: exactly 4*W*HALF_BCLK_DIV clks while enabled.
- enable deassertion:
  - Synchronous return to the idle state on the next clk edge.
  - Current frame is aborted.
  - Holding registers retain their contents.
- enable reassertion:
  - Fresh frame.
  - First sample_strobe coincides with the first bclk falling edge, 2*HALF_BCLK_DIV clks after the first enabled cycle.
- Async reset mid-frame: immediate idle values, no partial strobe; behaviour after release is identical to power-up.
- Input handling:
  - Inputs are sampled only on the capture cycle; changes at any other time have no effect.
  - A missing or late generator update simply retransmits the previous hold value. No error flag.
- Outputs are registered; no combinational paths from inputs to outputs.

Test Plan:
1. Reset check: rst=1 mid-frame, defaults → bclk, lrclk, sdata, sample_strobe all 0 immediately (asynchronously); after release with enable=1, first strobe exactly 8 clks later.
2. Timing: HALF_BCLK_DIV=4, W=16, enable=1 → bclk period 8 clks at 50% duty; sample_strobe 1 clk wide every 256 clks; lrclk period 256 clks, rising at the falling bclk edge that starts bit 15.
3. Data: generator holds left=16'hA5F0, right=16'h0F0F → second frame, read on rising bclk, gives bits A5F0 then 0F0F MSB first. Also check: lrclk=0 during the MSB of A5F0 and lrclk=1 during the LSB (bit 15); lrclk=1 from bit 15 through bit 30 and back to 0 at bit 31 (the LSB of 0F0F), one bit before the next frame's left MSB.
4. Latency/capture: change samples to 16'h8001/16'h7FFE exactly one clk after strobe N → transmitted in frame N+1. Change inputs at any other cycle → no effect on the frame.
5. Enable abort: drop enable at bit_cnt=20 → next clk all outputs idle. Re-enable → new frame starts with left MSB; strobe 8 clks after re-enable; holding values preserved.
6. Divider corner: HALF_BCLK_DIV=1 → bclk = clk/2, strobe every 64 clks, data pattern from test 3 still correct.

Source files
------------

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S stereo transmitter with integer bclk divider and per-frame sample request strobe
module i2s_tx #(
  parameter int HALF_BCLK_DIV = 4,
  parameter int SAMPLE_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] left_sample,
  input  logic [SAMPLE_W-1:0] right_sample,
  output logic                sample_strobe,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata
);

  localparam int DIV_W = (HALF_BCLK_DIV > 1) ? $clog2(HALF_BCLK_DIV) : 1;
  localparam int FRAME = 2 * SAMPLE_W;
  localparam int BIT_W = $clog2(FRAME);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);
  localparam logic [BIT_W-1:0] LR_FIRST = BIT_W'(SAMPLE_W - 1);
  localparam logic [BIT_W-1:0] LR_LAST  = BIT_W'(FRAME - 2);

  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [FRAME-1:0]    shreg;
  logic [SAMPLE_W-1:0] left_hold;
  logic [SAMPLE_W-1:0] right_hold;
  logic                cap_pending;

  logic                div_wrap;
  logic                fall;
  logic [BIT_W-1:0]    bit_next;
  logic                frame_start;

  always_comb begin
    div_wrap    = (div_cnt == DIV_LAST);
    fall        = div_wrap && bclk;
    bit_next    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    frame_start = fall && (bit_next == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt       <= '0;
      bit_cnt       <= BIT_LAST;
      bclk          <= 1'b0;
      lrclk         <= 1'b0;
      sdata         <= 1'b0;
      sample_strobe <= 1'b0;
      shreg         <= '0;
      left_hold     <= '0;
      right_hold    <= '0;
      cap_pending   <= 1'b0;
    end else if (!enable) begin
      // idle aborts the frame but keeps the last captured samples
      div_cnt       <= '0;
      bit_cnt       <= BIT_LAST;
      bclk          <= 1'b0;
      lrclk         <= 1'b0;
      sdata         <= 1'b0;
      sample_strobe <= 1'b0;
      shreg         <= '0;
      cap_pending   <= 1'b0;
    end else begin
      div_cnt       <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) bclk <= ~bclk;
      sample_strobe <= frame_start;
      cap_pending   <= sample_strobe;
      if (cap_pending) begin
        left_hold  <= left_sample;
        right_hold <= right_sample;
      end
      if (fall) begin
        bit_cnt <= bit_next;
        lrclk   <= (bit_next >= LR_FIRST) && (bit_next <= LR_LAST);
        // the left MSB goes straight out; the register keeps the remaining bits
        if (frame_start) begin
          sdata <= left_hold[SAMPLE_W-1];
          shreg <= {left_hold[SAMPLE_W-2:0], right_hold, 1'b0};
        end else begin
          sdata <= shreg[FRAME-1];
          shreg <= {shreg[FRAME-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed checks of i2s_tx timing, data, capture, abort, reset and divider corner
module tb_i2s_tx;

  logic        clk;
  logic        rst;
  logic        en4;
  logic        en1;
  logic [15:0] left_sample;
  logic [15:0] right_sample;
  logic        strobe4, bclk4, lrclk4, sdata4;
  logic        strobe1, bclk1, lrclk1, sdata1;
  logic        sel;
  logic        m_strobe, m_bclk, m_lrclk, m_sdata;
  int          total;
  int          bad;

  i2s_tx #(.HALF_BCLK_DIV(4), .SAMPLE_W(16)) dut4 (
    .clk(clk), .rst(rst), .enable(en4),
    .left_sample(left_sample), .right_sample(right_sample),
    .sample_strobe(strobe4), .bclk(bclk4), .lrclk(lrclk4), .sdata(sdata4)
  );

  i2s_tx #(.HALF_BCLK_DIV(1), .SAMPLE_W(16)) dut1 (
    .clk(clk), .rst(rst), .enable(en1),
    .left_sample(left_sample), .right_sample(right_sample),
    .sample_strobe(strobe1), .bclk(bclk1), .lrclk(lrclk1), .sdata(sdata1)
  );

  assign m_strobe = sel ? strobe1 : strobe4;
  assign m_bclk   = sel ? bclk1   : bclk4;
  assign m_lrclk  = sel ? lrclk1  : lrclk4;
  assign m_sdata  = sel ? sdata1  : sdata4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (m_strobe !== 1'b1 && n < 2000);
    chk(tag, n, exp);
  endtask

  // Called in the cycle where the strobe is visible; reads one frame on rising bclk.
  task automatic read_frame(input string tag, input logic [31:0] exp_d, input bit do_chg);
    int          per;
    int          rises;
    int          highs;
    int          extra;
    logic [31:0] d;
    logic [31:0] lr;
    logic        prev;
    per   = sel ? 64 : 256;
    rises = 0;
    highs = 0;
    extra = 0;
    d     = '0;
    lr    = '0;
    prev  = m_bclk;
    for (int i = 1; i <= per; i++) begin
      tick();
      if (do_chg && i == 1) begin
        left_sample  = 16'h8001;
        right_sample = 16'h7FFE;
      end
      if (do_chg && i == 5) begin
        left_sample  = 16'h1234;
        right_sample = 16'h5678;
      end
      if (m_bclk && !prev) begin
        rises++;
        d  = {d[30:0], m_sdata};
        lr = {lr[30:0], m_lrclk};
      end
      if (m_bclk) highs++;
      if (i < per && m_strobe) extra++;
      prev = m_bclk;
    end
    chk({tag, "_data"}, d, exp_d);
    chk({tag, "_lrclk"}, lr, 32'h0001_FFFE);
    chk({tag, "_rises"}, rises, 32);
    chk({tag, "_highs"}, highs, per / 2);
    chk({tag, "_extra_strobe"}, extra, 0);
    chk({tag, "_next_strobe"}, m_strobe, 1'b1);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    sel          = 1'b0;
    rst          = 1'b1;
    en4          = 1'b0;
    en1          = 1'b0;
    left_sample  = 16'h0000;
    right_sample = 16'h0000;
    #3;
    chk("reset_outs4", {bclk4, lrclk4, sdata4, strobe4}, 4'b0000);
    chk("reset_outs1", {bclk1, lrclk1, sdata1, strobe1}, 4'b0000);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // generator holds A5F0/0F0F; frame 1 carries reset holds, frame 2 the samples
    left_sample  = 16'hA5F0;
    right_sample = 16'h0F0F;
    en4 = 1'b1;
    wait_strobe("first_strobe", 8);
    read_frame("f1", 32'h0000_0000, 1'b0);
    read_frame("f2", 32'hA5F0_0F0F, 1'b0);
    read_frame("f3", 32'hA5F0_0F0F, 1'b1);
    read_frame("f4", 32'h8001_7FFE, 1'b0);

    // abort inside bit 20 of frame 5 while bclk and lrclk are high
    for (int i = 0; i < 165; i++) tick();
    chk("pre_abort", {bclk4, lrclk4}, 2'b11);
    en4 = 1'b0;
    tick();
    chk("abort_idle", {bclk4, lrclk4, sdata4, strobe4}, 4'b0000);
    for (int i = 0; i < 10; i++) tick();
    left_sample  = 16'hDEAD;
    right_sample = 16'hBEEF;
    en4 = 1'b1;
    wait_strobe("reen_strobe", 8);
    read_frame("f_reen", 32'h1234_5678, 1'b0);

    // asynchronous reset in the middle of a clk cycle
    for (int i = 0; i < 165; i++) tick();
    chk("pre_rst", {bclk4, lrclk4}, 2'b11);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_idle", {bclk4, lrclk4, sdata4, strobe4}, 4'b0000);
    tick();
    chk("rst_held_idle", {bclk4, lrclk4, sdata4, strobe4}, 4'b0000);
    rst = 1'b0;
    wait_strobe("rst_strobe", 8);
    read_frame("f_rst", 32'h0000_0000, 1'b0);

    // divider corner on the HALF_BCLK_DIV=1 instance
    en4 = 1'b0;
    tick();
    sel          = 1'b1;
    left_sample  = 16'hA5F0;
    right_sample = 16'h0F0F;
    en1 = 1'b1;
    wait_strobe("h1_strobe", 2);
    read_frame("h1_f1", 32'h0000_0000, 1'b0);
    read_frame("h1_f2", 32'hA5F0_0F0F, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
